fsk16_symbol_mapper: RTL and testbench
======================================

# fsk16_symbol_mapper

Upstream stage of the 16-FSK transmit DDS. It accepts a byte stream over a valid/ready handshake and buffers it in a small FIFO. Each byte is split into two 4-bit symbols, and each symbol is mapped to the 8-bit frequency code the DDS stage consumes. Each code is held for exactly one symbol period of `SYM_LEN` clocks. Its symbol counter is reset and clocked together with the DDS waveform address counter, so code changes always land at DDS address 0, ahead of the DDS sampling point at address 2.

## Interface
- `SYM_LEN`, 80: clocks per symbol; must equal the DDS waveform length.
- `FIFO_DEPTH`, 4: byte FIFO depth; must be a power of 2, at least 2.
- `IDLE_CODE`, 8'h00: code driven when no symbol is available (DDS treats it as no output).

Ports:
- `clk` in 1: single system clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `din` in 8: input byte.
- `din_valid` in 1: `din` is valid.
- `din_ready` out 1: FIFO can accept a byte.
- `freq` out 8: frequency code to the DDS `freq` input.
- `sym_start` out 1: one-cycle pulse in the first cycle of every symbol period.
- `busy` out 1: `freq` currently carries a data symbol (not `IDLE_CODE`).

## Operation
- **Symbol counter `sym_cnt`**
  - Width is ceil(log2(`SYM_LEN`)); counts 0..`SYM_LEN`-1 and wraps.
  - Free-running from reset, independent of whether data is present.
  - `boundary` is true when `sym_cnt` == `SYM_LEN`-1.
- **Byte FIFO**
  - A byte is written when `din_valid` && `din_ready`.
  - `din_ready` = !full. It is a registered/state-derived signal with no combinational path from `din_valid`.
  - When full, `din_ready` = 0 even if a pop occurs in the same cycle.
  - Pointers wrap modulo `FIFO_DEPTH`. An occupancy count (0..`FIFO_DEPTH`) gives full/empty.
- **Serializer state** (registered):
  - IDLE: no pending nibble.
  - LOW_PEND: low nibble of the current byte held in `lo_reg`.
- **Actions on a boundary edge:**
  - If LOW_PEND: emit `lo_reg` and go to IDLE. This takes priority over the FIFO.
  - Else if FIFO non-empty: pop a byte, emit `byte[7:4]`, store `byte[3:0]` in `lo_reg`, go to LOW_PEND.
  - Else: `freq` <= `IDLE_CODE`, `busy` <= 0.
  - Emitting nibble n sets `freq` <= 8'hE2 + {n,2'b00} (mod 256) and `busy` <= 1.
  - Resulting map: 0->E2, 1->E6, ..., 7->FE, 8->02, ..., 15->1E. This is strictly ascending tone from -30 to +30 in steps of 4.
- **Outputs between boundaries:** `freq` and `busy` change only on boundary edges.
- **`sym_start`:** registered; equals 1 exactly when `sym_cnt` == 0.
- **Push and pop in the same cycle** (FIFO neither full nor empty): occupancy is unchanged and both take effect.
- **Byte order:** high nibble always precedes low nibble. Bytes leave in arrival order with no gaps while the FIFO is non-empty.

## Timing
- **Reset values (asynchronous):**
  - `sym_cnt` = 0, FIFO empty, state IDLE, `lo_reg` = 0.
  - `freq` = `IDLE_CODE`, `busy` = 0.
  - `sym_start` = 1, since `sym_cnt` = 0 in reset.
  - `din_ready` = 1.
- **Reset mid-operation:** all buffered bytes and any pending nibble are discarded, and outputs return to their reset values immediately.
- **Latency:** a byte accepted at any cycle before a boundary edge, into an empty FIFO with the serializer IDLE, has its high nibble on `freq` from the cycle after that boundary edge, i.e. `sym_cnt` == 0.
  - Worst case is `SYM_LEN` cycles plus 1.
  - A byte accepted on the boundary edge itself waits one more symbol.
- **Per-byte timing:** each byte occupies `freq` for 2×`SYM_LEN` cycles.
- **Sustained throughput:** one byte per 2×`SYM_LEN` clocks. The upstream source sees backpressure via `din_ready` once `FIFO_DEPTH` bytes are queued.
- **DDS sampling:** `freq` is stable for all cycles with `sym_cnt` in 0..`SYM_LEN`-1 after update. This guarantees the DDS samples the new code at its address 2.

## Test plan
- **Reset and idle:**
  - Stimulus: assert `rst`=0 mid-symbol, release it, send no data for 300 cycles.
  - Required: `freq`=8'h00 and `busy`=0 throughout.
  - Required: `sym_start` pulses at cycles 0, 80, 160, 240.
- **Single byte:**
  - Stimulus: push 8'h7A at cycle 5 after reset.
  - Required: `freq`=FE for `sym_cnt` cycles 80..159, then 0A for 160..239, then 00 with `busy`=0 from 240.
- **Full map:**
  - Stimulus: push 8'h01, 23, 45, 67, 89, AB, CD, EF, respecting `din_ready`.
  - Required: consecutive symbols E2, E6, EA, ..., FE, 02, ..., 1E, each held exactly 80 cycles with no idle gaps.
- **Backpressure:**
  - Stimulus: hold `din_valid`=1 continuously.
  - Required: `din_ready` deasserts after 4 bytes are queued and reasserts only for the cycle after each pop.
  - Required: no byte is lost or duplicated; the output sequence equals the input sequence.
- **Simultaneous push and pop at a boundary:**
  - Stimulus: FIFO holding 2 bytes; push a byte on the edge where `sym_cnt`=79 while a pop occurs.
  - Required: occupancy stays 2 and ordering is preserved.
- **Reset mid-byte:**
  - Stimulus: pull `rst` low while `freq`=high nibble of 8'h3C (EE).
  - Required: `freq`=00 immediately and the FIFO is empty.
  - Required: after release, the low nibble C (12, code 12) never appears.

Source files
------------

// File: rtl/fsk16_symbol_mapper_if.sv
// fsk16_symbol_mapper_if: byte-input handshake and DDS-facing outputs of the 16-FSK mapper.
//   din       : input byte (source -> mapper)
//   din_valid : din is valid (source -> mapper)
//   din_ready : mapper FIFO can accept a byte (mapper -> source)
//   freq      : 8-bit frequency code for the DDS (mapper -> DDS)
//   sym_start : one-cycle pulse in the first cycle of each symbol period
//   busy      : freq carries a data symbol rather than the idle code
interface fsk16_symbol_mapper_if;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;
    logic [7:0] freq;
    logic       sym_start;
    logic       busy;

    // Source / observer side
    modport master (
        output din,
        output din_valid,
        input  din_ready,
        input  freq,
        input  sym_start,
        input  busy
    );

    // Mapper side
    modport slave (
        input  din,
        input  din_valid,
        output din_ready,
        output freq,
        output sym_start,
        output busy
    );
endinterface

// File: rtl/fsk16_symbol_mapper.sv
// fsk16_symbol_mapper: buffers bytes in a small FIFO, splits each into two nibbles (high first)
// and maps each nibble to an 8-bit DDS frequency code held for SYM_LEN clocks.
//   clk : system clock, rising edge
//   rst : asynchronous active-low reset
//   bus : fsk16_symbol_mapper_if.slave (din/din_valid/din_ready in, freq/sym_start/busy out)
module fsk16_symbol_mapper #(
    parameter int unsigned SYM_LEN    = 80,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [7:0]  IDLE_CODE  = 8'h00
) (
    input logic                   clk,
    input logic                   rst,
    fsk16_symbol_mapper_if.slave  bus
);

    localparam int unsigned CntW = $clog2(SYM_LEN);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned OccW = PtrW + 1;
    localparam logic [CntW-1:0] CntMax = CntW'(SYM_LEN - 1);
    localparam logic [OccW-1:0] OccFull = OccW'(FIFO_DEPTH);

    typedef enum logic {StIdle, StLowPend} ser_state_e;

    // Tone ascends -30..+30 in steps of 4; 8-bit wraparound folds the upper half into 02..1E.
    function automatic logic [7:0] nibble_code(input logic [3:0] n);
        return 8'hE2 + {2'b00, n, 2'b00};
    endfunction

    logic [CntW-1:0] sym_cnt;
    logic            sym_start_q;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr;
    logic [PtrW-1:0] rd_ptr;
    logic [OccW-1:0] occ;
    ser_state_e      state;
    logic [3:0]      lo_reg;
    logic [7:0]      freq_q;
    logic            busy_q;

    logic boundary;
    logic full;
    logic empty;
    logic push;
    logic pop;

    assign boundary = (sym_cnt == CntMax);
    assign full     = (occ == OccFull);
    assign empty    = (occ == '0);
    // Ready depends only on occupancy, so a pop in the same cycle never re-opens a full FIFO.
    assign push     = bus.din_valid && !full;
    // A pending low nibble outranks the FIFO, so pops happen only from StIdle.
    assign pop      = boundary && (state == StIdle) && !empty;

    // Free-running symbol counter, kept in lockstep with the DDS address counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sym_cnt     <= '0;
            sym_start_q <= 1'b1;
        end else begin
            sym_cnt     <= boundary ? '0 : sym_cnt + 1'b1;
            sym_start_q <= boundary;
        end
    end

    // FIFO storage needs no reset; occupancy alone defines what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    // Serializer: freq/busy move only on boundary edges so the DDS sees a stable code.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= StIdle;
            lo_reg <= 4'h0;
            freq_q <= IDLE_CODE;
            busy_q <= 1'b0;
        end else if (boundary) begin
            if (state == StLowPend) begin
                freq_q <= nibble_code(lo_reg);
                busy_q <= 1'b1;
                state  <= StIdle;
            end else if (!empty) begin
                freq_q <= nibble_code(mem[rd_ptr][7:4]);
                lo_reg <= mem[rd_ptr][3:0];
                busy_q <= 1'b1;
                state  <= StLowPend;
            end else begin
                freq_q <= IDLE_CODE;
                busy_q <= 1'b0;
            end
        end
    end

    assign bus.din_ready = !full;
    assign bus.freq      = freq_q;
    assign bus.sym_start = sym_start_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_fsk16_symbol_mapper.sv
// tb_fsk16_symbol_mapper: scoreboard bench for fsk16_symbol_mapper. Accepted bytes push their two
// expected codes; the code is popped and compared at each symbol start and held for the symbol.
module tb_fsk16_symbol_mapper;

    localparam int SymLen = 80;

    logic clk = 1'b0;
    logic rst = 1'b0;

    fsk16_symbol_mapper_if bus ();

    fsk16_symbol_mapper #(
        .SYM_LEN    (SymLen),
        .FIFO_DEPTH (4),
        .IDLE_CODE  (8'h00)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         phase    = 0;
    int         eligible = 0;
    logic [7:0] exp_q [$];
    logic [7:0] cur_exp  = 8'h00;
    logic       cur_busy = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Tone index -30 + 4n expressed as an 8-bit two's-complement code.
    function automatic logic [7:0] tone_code(input logic [3:0] n);
        int t;
        t = -30 + 4 * int'(n);
        return 8'(t);
    endfunction

    // Phase tracker and scoreboard push; codes queued before a boundary edge become eligible.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase    = 0;
            eligible = 0;
            exp_q.delete();
            cur_exp  = 8'h00;
            cur_busy = 1'b0;
        end else begin
            if (phase == SymLen - 1) eligible = exp_q.size();
            if (bus.din_valid && bus.din_ready) begin
                exp_q.push_back(tone_code(bus.din[7:4]));
                exp_q.push_back(tone_code(bus.din[3:0]));
            end
            phase = (phase == SymLen - 1) ? 0 : phase + 1;
        end
    end

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            check_eq("sym_start", bus.sym_start, phase == 0);
            if (phase == 0) begin
                if (eligible > 0) begin
                    cur_exp  = exp_q.pop_front();
                    cur_busy = 1'b1;
                end else begin
                    cur_exp  = 8'h00;
                    cur_busy = 1'b0;
                end
            end
            check_eq("freq", bus.freq, cur_exp);
            check_eq("busy", bus.busy, cur_busy);
        end
    end

    task automatic wait_phase(input int p);
        int n = 0;
        while (phase != p && n < 2 * SymLen) begin
            @(negedge clk);
            n++;
        end
        check_eq("wait_phase", phase, p);
    endtask

    // Called on a falling edge; returns on the falling edge after the byte is taken.
    task automatic send(input logic [7:0] b);
        int n = 0;
        bus.din       = b;
        bus.din_valid = 1'b1;
        while (!bus.din_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check_eq("send_ready", bus.din_ready, 1);
        @(negedge clk);
        bus.din_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain", exp_q.size(), 0);
        repeat (2 * SymLen + 2) @(negedge clk);
    endtask

    task automatic reset_pulse();
        rst = 1'b0;
        #1;
        check_eq("rst_freq", bus.freq, 8'h00);
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_sym_start", bus.sym_start, 1);
        check_eq("rst_din_ready", bus.din_ready, 1);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected test end");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        int         n;
        bus.din       = 8'h00;
        bus.din_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // Reset mid-symbol, then idle for 300 cycles.
        repeat (37) @(negedge clk);
        reset_pulse();
        repeat (300) @(negedge clk);

        // Single byte 7A pushed 5 cycles after reset: FE then 0A then idle.
        reset_pulse();
        repeat (5) @(negedge clk);
        send(8'h7A);
        drain();

        // Full nibble map, bytes back to back.
        for (int i = 0; i < 8; i++) begin
            send(8'h01 + 8'(8'h22 * i));
        end
        drain();

        // Backpressure: din_valid held high across 8 bytes.
        wait_phase(1);
        bus.din_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            b       = 8'($urandom());
            bus.din = b;
            n       = 0;
            while (!bus.din_ready && n < 1000) begin
                @(negedge clk);
                n++;
            end
            check_eq("bp_ready", bus.din_ready, 1);
            @(negedge clk);
            if (i >= 3) check_eq("bp_ready_low", bus.din_ready, 0);
        end
        bus.din_valid = 1'b0;
        drain();

        // Push coinciding with a pop on the boundary edge, FIFO holding 2 bytes.
        wait_phase(1);
        send(8'h91);
        send(8'hA2);
        send(8'hB3);
        wait_phase(0);
        wait_phase(SymLen - 1);
        wait_phase(0);
        wait_phase(SymLen - 1);
        send(8'hC4);
        check_eq("sim_ready_d", bus.din_ready, 1);
        send(8'hD5);
        check_eq("sim_ready_e", bus.din_ready, 1);
        send(8'hE6);
        check_eq("sim_full_f", bus.din_ready, 0);
        drain();

        // Reset while 3C high nibble is on air with 55 still queued.
        wait_phase(1);
        send(8'h3C);
        send(8'h55);
        wait_phase(0);
        wait_phase(40);
        check_eq("pre_rst_freq", bus.freq, 8'hEE);
        reset_pulse();
        repeat (400) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
